// File: rtl/pipe_sub_16b_pkg.sv
// Shared widths, carry-skip group sizes and the stage-1 register record for pipe_sub_16b.
package pipe_sub_16b_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SPLIT  = 8;
  localparam int unsigned HI_W   = DATA_W - SPLIT;
  localparam int unsigned G0_W   = 3;
  localparam int unsigned G1_W   = 3;
  localparam int unsigned G2_W   = 2;

  // Upper operand halves, borrow out of bit 7 and the finished low difference byte
  typedef struct packed {
    logic [HI_W-1:0]  a_hi;
    logic [HI_W-1:0]  b_hi;
    logic             borrow;
    logic [SPLIT-1:0] d_lo;
  } s1_t;

endpackage

// File: rtl/sub_pg_3b.sv
// Ripple slice of up to 3 bits: sum bits plus group propagate/generate for carry-skip.
module sub_pg_3b #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         p,
  output logic         g
);

  // g is the slice carry-out assuming a zero carry-in
  always_comb begin : ripple
    logic c;
    logic gc;
    c  = cin;
    gc = 1'b0;
    p  = 1'b1;
    s  = '0;
    for (int i = 0; i < int'(W); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
      gc   = (x[i] & y[i]) | ((x[i] ^ y[i]) & gc);
      p    = p & (x[i] ^ y[i]);
    end
    g = gc;
  end

endmodule

// File: rtl/pipe_sub_16b.sv
// Two-stage valid/ready 16-bit subtractor: low byte in stage 1, high byte and flags in stage 2.
module pipe_sub_16b
  import pipe_sub_16b_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] d,
  output logic              bout,
  output logic              ovf
);

  localparam int unsigned G01_W = G0_W + G1_W;

  s1_t  s1;
  logic v1;
  logic adv2;

  logic [1:0][SPLIT-1:0] sx;
  logic [1:0][SPLIT-1:0] sy;
  logic [1:0][SPLIT-1:0] ss;
  logic [1:0]            scin;
  logic [1:0]            scout;

  // Subtraction as a + ~b + ~borrow; index 0 is the low byte, index 1 the high byte
  assign sx[0]   = a[SPLIT-1:0];
  assign sy[0]   = ~b[SPLIT-1:0];
  assign scin[0] = ~bin;
  assign sx[1]   = s1.a_hi;
  assign sy[1]   = ~s1.b_hi;
  assign scin[1] = ~s1.borrow;

  for (genvar k = 0; k < 2; k++) begin : g_slice
    logic [2:0] gp;
    logic [2:0] gg;
    logic       c1;
    logic       c2;

    sub_pg_3b #(.W(G0_W)) u_g0 (
      .x   (sx[k][G0_W-1:0]),
      .y   (sy[k][G0_W-1:0]),
      .cin (scin[k]),
      .s   (ss[k][G0_W-1:0]),
      .p   (gp[0]),
      .g   (gg[0])
    );

    assign c1 = gp[0] ? scin[k] : gg[0];

    sub_pg_3b #(.W(G1_W)) u_g1 (
      .x   (sx[k][G01_W-1:G0_W]),
      .y   (sy[k][G01_W-1:G0_W]),
      .cin (c1),
      .s   (ss[k][G01_W-1:G0_W]),
      .p   (gp[1]),
      .g   (gg[1])
    );

    assign c2 = gp[1] ? c1 : gg[1];

    sub_pg_3b #(.W(G2_W)) u_g2 (
      .x   (sx[k][SPLIT-1:G01_W]),
      .y   (sy[k][SPLIT-1:G01_W]),
      .cin (c2),
      .s   (ss[k][SPLIT-1:G01_W]),
      .p   (gp[2]),
      .g   (gg[2])
    );

    assign scout[k] = gp[2] ? c2 : gg[2];
  end

  // Stage 2 moves when empty or draining; stage 1 when empty or moving into stage 2
  assign adv2     = ~out_valid | out_ready;
  assign in_ready = ~v1 | adv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (in_ready) begin
      v1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1.a_hi   <= a[DATA_W-1:SPLIT];
      s1.b_hi   <= b[DATA_W-1:SPLIT];
      s1.borrow <= ~scout[0];
      s1.d_lo   <= ss[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        d    <= {ss[1], s1.d_lo};
        bout <= ~scout[1];
        ovf  <= (s1.a_hi[HI_W-1] ^ s1.b_hi[HI_W-1]) & (ss[1][SPLIT-1] ^ s1.a_hi[HI_W-1]);
      end
    end
  end

endmodule

// File: tb/tb_pipe_sub_16b.sv
// Directed and random checks of pipe_sub_16b against an integer-arithmetic reference.
module tb_pipe_sub_16b;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
  logic        ovf;

  int          errors = 0;
  int          checks = 0;
  int          n_acc  = 0;
  logic [17:0] q[$];
  logic        prev_hold = 1'b0;
  logic [17:0] prev_out  = '0;
  logic        last_in_ready = 1'b0;
  logic        last_out_fire = 1'b0;

  always #5 clk = ~clk;

  pipe_sub_16b dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  // {d, bout, ovf} from plain unsigned and signed integer arithmetic
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
    int ux, uy, sxv, syv, sd;
    logic bo, ov;
    ux  = int'(x);
    uy  = int'(y);
    sxv = int'($signed(x));
    syv = int'($signed(y));
    bo  = (ux < uy + int'(bi));
    sd  = sxv - syv - int'(bi);
    ov  = (sd > 32767) || (sd < -32768);
    return {16'(ux - uy - int'(bi)), bo, ov};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check/score just after, then wait for the rising edge
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ibin, input logic ordy);
    logic [17:0] exp;
    @(negedge clk);
    rst = 1'b0; in_valid = iv; a = ia; b = ib; bin = ibin; out_ready = ordy;
    #1;
    if (prev_hold) begin
      chk("hold_valid", 32'(out_valid), 32'(1));
      chk("hold_data", 32'({d, bout, ovf}), 32'(prev_out));
    end
    last_out_fire = out_valid && out_ready;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'(0));
      end else begin
        exp = q.pop_front();
        chk("result", 32'({d, bout, ovf}), 32'(exp));
      end
    end
    last_in_ready = in_ready;
    if (in_valid && in_ready) begin
      q.push_back(ref_sub(ia, ib, ibin));
      n_acc++;
    end
    prev_hold = out_valid && !out_ready;
    prev_out  = {d, bout, ovf};
    @(posedge clk);
  endtask

  // Reset with a valid operand presented; nothing may be accepted or emitted afterwards
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 16'h5555; b = 16'h1111; bin = 1'b0; out_ready = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_d", 32'(d), 32'(0));
    chk("rst_bout", 32'(bout), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    q.delete();
    prev_hold = 1'b0;
  endtask

  task automatic single_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                           input logic [15:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; bin = ibin; out_ready = 1'b1;
    #1;
    chk("vec_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("vec_lat1_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("vec_lat2_valid", 32'(out_valid), 32'(1));
    chk("vec_d", 32'(d), 32'(ed));
    chk("vec_bout", 32'(bout), 32'(eb));
    chk("vec_ovf", 32'(ovf), 32'(eo));
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("vec_drained", 32'(out_valid), 32'(0));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    do_reset(2);

    single_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    single_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    single_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    single_op(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    single_op(16'h00FF, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1'b0);
    single_op(16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    single_op(16'h0080, 16'h0081, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: two sets fill the pipe, the third waits
    cycle(1'b1, 16'h1000, 16'h0001, 1'b0, 1'b0);
    cycle(1'b1, 16'h2000, 16'h0FFF, 1'b1, 1'b0);
    cycle(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(last_in_ready), 32'(0));
    cycle(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0);
    chk("bp_in_ready_still_low", 32'(last_in_ready), 32'(0));
    cycle(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b1);
    chk("bp_fire1", 32'(last_out_fire), 32'(1));
    chk("bp_third_accepted", 32'(last_in_ready), 32'(1));
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("bp_fire2", 32'(last_out_fire), 32'(1));
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("bp_fire3", 32'(last_out_fire), 32'(1));
    cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    chk("bp_fire_none", 32'(last_out_fire), 32'(0));
    chk("bp_queue_empty", 32'(q.size()), 32'(0));

    // Reset with two sets in flight
    cycle(1'b1, 16'hAAAA, 16'h0001, 1'b0, 1'b0);
    cycle(1'b1, 16'hBBBB, 16'h0002, 1'b0, 1'b0);
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      chk("post_rst_no_out", 32'(last_out_fire), 32'(0));
    end

    // Random stream with random valid/ready
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      cycle(($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0));
      cyc++;
    end
    if (n_acc < 10000) chk("stream_timeout", 32'(n_acc), 32'(10000));
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      cycle(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
